// File: rtl/exc_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// exc_seq -- exception / interrupt sequencer in front of coprocessor 0.
//
// Accepts one trap event (eret, syscall, break or an enabled interrupt) while
// idle, then walks CP0's register port one access per cycle: save EPC, write
// CAUSE, read-modify-write STATUS (set EXL), and finally redirects fetch to
// the exception vector. An eret reads the return target through the CP0 RET
// operation and redirects there instead. Fetch/decode are stalled for the
// whole sequence.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req_sys/brk/eret trap requests from decode (held by decode while stalled)
//   req_pc          PC of the decode instruction
//   irq, irq_mask   level-sensitive interrupt lines and their mask
//   status_ie/exl   STATUS.IE / STATUS.EXL shadows
//   cop_rdata       CP0 read data
//   cop_op          CP0 operation (COP_OP_MV or COP_OP_RET)
//   cop_reg_num/sel CP0 register address, zero when no strobe is high
//   cop_wdata       CP0 write data, zero when no strobe is high
//   cop_wr, cop_rd  CP0 write / read strobes, never high together
//   stall, flush    pipeline hold and squash
//   redirect_valid  one-cycle PC redirect, target on redirect_pc
//
// Request handshake: a request is a level, not a pulse. It is sampled only on
// a rising edge while the sequencer is idle; while busy (stall=1) requests are
// ignored and decode keeps presenting them until they are taken.
// -----------------------------------------------------------------------------
module exc_seq #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_3000,
  parameter logic [31:0] BOOT_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_sys,
  input  logic        req_brk,
  input  logic        req_eret,
  input  logic [31:0] req_pc,
  input  logic [5:0]  irq,
  input  logic [5:0]  irq_mask,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [31:0] cop_rdata,
  output logic [2:0]  cop_op,
  output logic [4:0]  cop_reg_num,
  output logic [2:0]  cop_reg_sel,
  output logic [31:0] cop_wdata,
  output logic        cop_wr,
  output logic        cop_rd,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [2:0] COP_OP_MV  = 3'd0;
  localparam logic [2:0] COP_OP_RET = 3'd1;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_WR_EPC,
    S_WR_CAUSE,
    S_RD_STATUS,
    S_WR_STATUS,
    S_REDIRECT,
    S_ERET
  } state_t;

  state_t      state;
  logic [31:0] epc_q;
  logic [5:0]  ip_q;
  logic [4:0]  exccode_q;
  // Only STATUS.BEV is needed after the read; the full word goes straight
  // into the STATUS write data on the same edge it is captured.
  logic        stat_bev_q;

  logic irq_hit;
  assign irq_hit = (|(irq & irq_mask)) & status_ie & ~status_exl;

  // Outputs are registered and always describe the state being entered, so
  // each output is a pure function of the current state register plus the
  // latched operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      epc_q          <= '0;
      ip_q           <= '0;
      exccode_q      <= '0;
      stat_bev_q     <= 1'b0;
      cop_op         <= COP_OP_MV;
      cop_reg_num    <= '0;
      cop_reg_sel    <= '0;
      cop_wdata      <= '0;
      cop_wr         <= 1'b0;
      cop_rd         <= 1'b0;
      stall          <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      cop_op         <= COP_OP_MV;
      cop_reg_num    <= '0;
      cop_reg_sel    <= '0;
      cop_wdata      <= '0;
      cop_wr         <= 1'b0;
      cop_rd         <= 1'b0;
      stall          <= 1'b1;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;

      case (state)
        S_IDLE: begin
          if (req_eret) begin
            state  <= S_ERET;
            cop_op <= COP_OP_RET;
            flush  <= 1'b1;
          end else if (req_sys || req_brk || irq_hit) begin
            state <= S_FLUSH;
            flush <= 1'b1;
            // The trapping or interrupted instruction re-executes, so EPC is
            // its own PC in every case. Pending lines are recorded even when
            // a synchronous trap wins.
            epc_q <= req_pc;
            ip_q  <= irq;
            if (req_sys)      exccode_q <= EXC_SYS;
            else if (req_brk) exccode_q <= EXC_BP;
            else              exccode_q <= EXC_INT;
          end else begin
            stall <= 1'b0;
          end
        end

        S_FLUSH: begin
          state       <= S_WR_EPC;
          cop_wr      <= 1'b1;
          cop_reg_num <= REG_EPC;
          cop_wdata   <= epc_q;
        end

        S_WR_EPC: begin
          state       <= S_WR_CAUSE;
          cop_wr      <= 1'b1;
          cop_reg_num <= REG_CAUSE;
          cop_wdata   <= {16'h0000, ip_q, 3'b000, exccode_q, 2'b00};
        end

        S_WR_CAUSE: begin
          state       <= S_RD_STATUS;
          cop_rd      <= 1'b1;
          cop_reg_num <= REG_STATUS;
        end

        S_RD_STATUS: begin
          state       <= S_WR_STATUS;
          stat_bev_q  <= cop_rdata[22];
          cop_wr      <= 1'b1;
          cop_reg_num <= REG_STATUS;
          cop_wdata   <= cop_rdata | 32'h0000_0002;
        end

        S_WR_STATUS: begin
          state          <= S_REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= stat_bev_q ? BOOT_VECTOR : EXC_VECTOR;
        end

        S_ERET: begin
          // CP0 presents the return target during the RET cycle.
          state          <= S_REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= cop_rdata;
        end

        S_REDIRECT: begin
          state <= S_IDLE;
          stall <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule
